// File: rtl/axis_pkg.sv
// Shared types and widths for the AXIS receive endpoint.
package axis_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned USER_W  = 2;
  localparam int unsigned ENTRY_W = DATA_W + STRB_W + KEEP_W + USER_W + 1;

  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_BUSY = 2'd1,
    PKT_DONE = 2'd2
  } axis_pkt_state_e;

  // FIFO entry, MSB first: {tdata, tstrb, tkeep, tuser, tlast}
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } axis_entry_t;

endpackage

// File: rtl/axis_rx_fifo.sv
// First-word-fall-through FIFO; head entry reads as zero when empty.
module axis_rx_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_rdy  = ~full;
  assign rd_vld  = ~empty;
  assign wr_en   = wr_vld & ~full;
  assign rd_en   = rd_rdy & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Pointer update; wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage array, no reset needed since the head is masked when empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_slave.sv
// AXIS receive endpoint: buffers upstream beats and hands them to backend logic
// with packet tracking, per-packet beat count and stall timeout.
module axis_slave
  import axis_pkg::*;
#(
  parameter logic [7:0] FIFO_DEPTH     = 8'd8,
  parameter logic [7:0] BK_RDY_TIMEOUT = 8'd5
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        axis_tvalid,
  input  logic [31:0] axis_tdata,
  input  logic [3:0]  axis_tstrb,
  input  logic [3:0]  axis_tkeep,
  input  logic        axis_tlast,
  input  logic [1:0]  axis_tuser,
  output logic        axis_tready,
  output logic        bk_valid,
  output logic [31:0] bk_data,
  output logic [3:0]  bk_tstrb,
  output logic [3:0]  bk_tkeep,
  output logic [1:0]  bk_user,
  output logic        bk_last,
  input  logic        bk_ready,
  output logic [15:0] bk_beat_cnt,
  output logic        bk_done,
  output logic        bk_nordy
);

  axis_entry_t     wr_entry;
  axis_entry_t     head;
  logic [ENTRY_W-1:0] head_bits;
  logic            fifo_wr_rdy;
  logic            run_q;
  logic            null_beat;
  logic            push;
  logic            pop;
  axis_pkt_state_e state_q;
  axis_pkt_state_e state_d;
  logic [15:0]     cnt_d;
  logic [7:0]      stall_q;
  logic [7:0]      stall_d;

  // Null beats (no kept bytes, not last) are handshaked but never stored
  assign null_beat   = (axis_tkeep == 4'h0) && !axis_tlast;
  assign axis_tready = run_q & fifo_wr_rdy;
  assign push        = axis_tvalid & axis_tready & ~null_beat;
  assign pop         = bk_valid & bk_ready;

  assign wr_entry = '{tdata: axis_tdata, tstrb: axis_tstrb, tkeep: axis_tkeep,
                      tuser: axis_tuser, tlast: axis_tlast};

  axis_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (32'(FIFO_DEPTH))
  ) u_fifo (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .wr_vld  (push),
    .wr_rdy  (fifo_wr_rdy),
    .wr_data (wr_entry),
    .rd_vld  (bk_valid),
    .rd_rdy  (bk_ready),
    .rd_data (head_bits)
  );

  // Head-of-FIFO fields, already zero when empty
  assign head     = axis_entry_t'(head_bits);
  assign bk_data  = head.tdata;
  assign bk_tstrb = head.tstrb;
  assign bk_tkeep = head.tkeep;
  assign bk_user  = head.tuser;
  assign bk_last  = head.tlast;

  // Packet FSM, beat counter and stall counter next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = bk_beat_cnt;
    stall_d = stall_q;

    unique case (state_q)
      PKT_IDLE, PKT_DONE: begin
        if (pop) state_d = bk_last ? PKT_DONE : PKT_BUSY;
        else     state_d = PKT_IDLE;
      end
      PKT_BUSY: begin
        if (pop && bk_last) state_d = PKT_DONE;
      end
      default: state_d = PKT_IDLE;
    endcase

    // A pop during the done cycle starts the next packet at 1
    if (pop) begin
      if (state_q == PKT_DONE)          cnt_d = 16'd1;
      else if (bk_beat_cnt != 16'hFFFF) cnt_d = bk_beat_cnt + 16'd1;
    end else if (state_q == PKT_DONE) begin
      cnt_d = 16'd0;
    end

    if (pop || !bk_valid)     stall_d = 8'd0;
    else if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  // State and registered status outputs
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run_q       <= 1'b0;
      state_q     <= PKT_IDLE;
      bk_beat_cnt <= 16'd0;
      bk_done     <= 1'b0;
      stall_q     <= 8'd0;
      bk_nordy    <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      state_q     <= state_d;
      bk_beat_cnt <= cnt_d;
      bk_done     <= (state_d == PKT_DONE);
      stall_q     <= stall_d;
      bk_nordy    <= (stall_d >= BK_RDY_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_axis_slave.sv
// Directed bench for axis_slave: per-cycle vector table plus FIFO fill,
// stall timeout and mid-packet reset sequences.
module tb_axis_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb;
  logic [3:0]  axis_tkeep;
  logic        axis_tlast;
  logic [1:0]  axis_tuser;
  logic        axis_tready;
  logic        bk_valid;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb;
  logic [3:0]  bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        bk_ready;
  logic [15:0] bk_beat_cnt;
  logic        bk_done;
  logic        bk_nordy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_slave #(
    .FIFO_DEPTH     (8'd8),
    .BK_RDY_TIMEOUT (8'd5)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .axis_tvalid (axis_tvalid),
    .axis_tdata  (axis_tdata),
    .axis_tstrb  (axis_tstrb),
    .axis_tkeep  (axis_tkeep),
    .axis_tlast  (axis_tlast),
    .axis_tuser  (axis_tuser),
    .axis_tready (axis_tready),
    .bk_valid    (bk_valid),
    .bk_data     (bk_data),
    .bk_tstrb    (bk_tstrb),
    .bk_tkeep    (bk_tkeep),
    .bk_user     (bk_user),
    .bk_last     (bk_last),
    .bk_ready    (bk_ready),
    .bk_beat_cnt (bk_beat_cnt),
    .bk_done     (bk_done),
    .bk_nordy    (bk_nordy)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        r;
    logic        e_vld;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic r, input logic e_vld,
                              input logic [31:0] e_data, input logic [3:0] e_keep,
                              input logic e_last, input logic e_done, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.d = d; t.k = k; t.l = l; t.r = r;
    t.e_vld = e_vld; t.e_data = e_data; t.e_keep = e_keep;
    t.e_last = e_last; t.e_done = e_done; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Strobe and user sideband are derived from data bits so they vary per beat
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
    axis_tvalid = v;
    axis_tdata  = d;
    axis_tkeep  = k;
    axis_tlast  = l;
    axis_tstrb  = d[7:4];
    axis_tuser  = d[9:8];
  endtask

  logic [31:0] fill_d [12];
  int push_i;
  int pop_i;
  int done_seen;

  initial begin
    // Per-cycle table: inputs held for one cycle, outputs checked after the edge
    vec[0]  = mk(1, 32'hA5A5_0001, 4'hF, 1, 1,  1, 32'hA5A5_0001, 4'hF, 1, 0, 16'd0);
    vec[1]  = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 1, 16'd1);
    vec[2]  = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 16'd0);
    vec[3]  = mk(1, 32'h1111_0311, 4'hF, 0, 1,  1, 32'h1111_0311, 4'hF, 0, 0, 16'd0);
    vec[4]  = mk(1, 32'h2222_0222, 4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 16'd1);
    vec[5]  = mk(1, 32'h3333_01F3, 4'hF, 1, 1,  1, 32'h3333_01F3, 4'hF, 1, 0, 16'd1);
    vec[6]  = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 1, 16'd2);
    vec[7]  = mk(1, 32'h4444_0244, 4'h0, 1, 1,  1, 32'h4444_0244, 4'h0, 1, 0, 16'd0);
    vec[8]  = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 1, 16'd1);
    vec[9]  = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 16'd0);
    vec[10] = mk(1, 32'hB1B1_03A1, 4'hF, 0, 1,  1, 32'hB1B1_03A1, 4'hF, 0, 0, 16'd0);
    vec[11] = mk(1, 32'hB2B2_0152, 4'hF, 1, 1,  1, 32'hB2B2_0152, 4'hF, 1, 0, 16'd1);
    vec[12] = mk(1, 32'hC1C1_02C1, 4'hF, 0, 1,  1, 32'hC1C1_02C1, 4'hF, 0, 1, 16'd2);
    vec[13] = mk(1, 32'hC2C2_0372, 4'hF, 0, 1,  1, 32'hC2C2_0372, 4'hF, 0, 0, 16'd1);
    vec[14] = mk(1, 32'hC3C3_01E3, 4'hF, 1, 1,  1, 32'hC3C3_01E3, 4'hF, 1, 0, 16'd2);
    vec[15] = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 1, 16'd3);
    vec[16] = mk(0, 32'h0,         4'h0, 0, 1,  0, 32'h0,         4'h0, 0, 0, 16'd0);

    for (int i = 0; i < 12; i++) fill_d[i] = 32'hD000_0000 + 32'(i);

    // Reset values
    rst_n    = 1'b0;
    bk_ready = 1'b0;
    drive(0, 32'h0, 4'h0, 0);
    repeat (2) @(negedge clk);
    chk("rst_tready", 32'(axis_tready), 32'd0);
    chk("rst_valid",  32'(bk_valid),    32'd0);
    chk("rst_data",   bk_data,          32'd0);
    chk("rst_cnt",    32'(bk_beat_cnt), 32'd0);
    chk("rst_done",   32'(bk_done),     32'd0);
    chk("rst_nordy",  32'(bk_nordy),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 32'(axis_tready), 32'd1);

    // Table-driven: single beat, null beats, back-to-back packets
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].v, vec[i].d, vec[i].k, vec[i].l);
      bk_ready = vec[i].r;
      @(negedge clk);
      chk($sformatf("row%0d_vld", i),   32'(bk_valid),    32'(vec[i].e_vld));
      chk($sformatf("row%0d_data", i),  bk_data,          vec[i].e_data);
      chk($sformatf("row%0d_keep", i),  32'(bk_tkeep),    32'(vec[i].e_keep));
      chk($sformatf("row%0d_strb", i),  32'(bk_tstrb),    32'(vec[i].e_data[7:4]));
      chk($sformatf("row%0d_user", i),  32'(bk_user),     32'(vec[i].e_data[9:8]));
      chk($sformatf("row%0d_last", i),  32'(bk_last),     32'(vec[i].e_last));
      chk($sformatf("row%0d_done", i),  32'(bk_done),     32'(vec[i].e_done));
      chk($sformatf("row%0d_cnt", i),   32'(bk_beat_cnt), 32'(vec[i].e_cnt));
      chk($sformatf("row%0d_tready", i), 32'(axis_tready), 32'd1);
      chk($sformatf("row%0d_nordy", i), 32'(bk_nordy),    32'd0);
    end

    // 12-beat packet against a stalled backend: fill to 8, then drain
    bk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill%0d_tready", i), 32'(axis_tready), 32'd1);
      drive(1, fill_d[i], 4'hF, 0);
      @(negedge clk);
    end
    chk("full_tready", 32'(axis_tready), 32'd0);
    chk("full_head",   bk_data,          fill_d[0]);
    // Beat 8 offered while full and popping: must not be taken this cycle
    drive(1, fill_d[8], 4'hF, 0);
    bk_ready = 1'b1;
    @(negedge clk);
    chk("rise_tready", 32'(axis_tready), 32'd1);
    push_i    = 8;
    pop_i     = 1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bk_done) begin
        done_seen++;
        chk("pkt12_cnt", 32'(bk_beat_cnt), 32'd12);
      end
      if (bk_valid) begin
        if (pop_i < 12) begin
          chk($sformatf("pkt12_data%0d", pop_i), bk_data, fill_d[pop_i]);
          chk($sformatf("pkt12_last%0d", pop_i), 32'(bk_last), 32'(pop_i == 11));
        end
        pop_i++;
      end
      if (push_i < 12 && axis_tready) begin
        drive(1, fill_d[push_i], 4'hF, (push_i == 11));
        push_i++;
      end else begin
        drive(0, 32'h0, 4'h0, 0);
      end
      @(negedge clk);
    end
    chk("pkt12_pops",  32'(pop_i),     32'd12);
    chk("pkt12_pushes", 32'(push_i),   32'd12);
    chk("pkt12_dones", 32'(done_seen), 32'd1);

    // Stall timeout: one buffered beat, backend not ready for 7 cycles
    bk_ready = 1'b0;
    drive(1, 32'h5A5A_0001, 4'hF, 1);
    @(negedge clk);
    drive(0, 32'h0, 4'h0, 0);
    chk("stall0_nordy", 32'(bk_nordy), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_nordy", k), 32'(bk_nordy), 32'(k >= 5));
    end
    bk_ready = 1'b1;
    @(negedge clk);
    chk("stall_clear_nordy", 32'(bk_nordy), 32'd0);
    chk("stall_done",        32'(bk_done),  32'd1);
    @(negedge clk);

    // Reset in the middle of a 6-beat packet
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hE000_0000 + 32'(i), 4'hF, 0);
      @(negedge clk);
    end
    drive(0, 32'h0, 4'h0, 0);
    bk_ready = 1'b0;
    chk("mid_cnt_before", 32'(bk_beat_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", 32'(axis_tready), 32'd0);
    chk("mid_rst_valid",  32'(bk_valid),    32'd0);
    chk("mid_rst_data",   bk_data,          32'd0);
    chk("mid_rst_last",   32'(bk_last),     32'd0);
    chk("mid_rst_cnt",    32'(bk_beat_cnt), 32'd0);
    chk("mid_rst_done",   32'(bk_done),     32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_hold_done%0d", k), 32'(bk_done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_tready", 32'(axis_tready), 32'd1);
    chk("mid_post_valid",  32'(bk_valid),    32'd0);
    chk("mid_post_done",   32'(bk_done),     32'd0);
    bk_ready = 1'b1;
    drive(1, 32'hF00D_0001, 4'hF, 1);
    @(negedge clk);
    drive(0, 32'h0, 4'h0, 0);
    chk("after_rst_valid", 32'(bk_valid), 32'd1);
    chk("after_rst_data",  bk_data,       32'hF00D_0001);
    @(negedge clk);
    chk("after_rst_done",  32'(bk_done),     32'd1);
    chk("after_rst_cnt",   32'(bk_beat_cnt), 32'd1);
    @(negedge clk);
    chk("after_rst_done_end", 32'(bk_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_slave.md
# axis_slave

Receive-side AXI-Stream endpoint for the user-project AXI-Lite/AXIS bridge; the mirror of the transmit path that drains backend data onto AXIS. Accepts beats from an upstream AXIS master, buffers them in a small first-word-fall-through FIFO, and presents them to backend logic over a valid/ready interface. Reports packet boundaries, a per-packet beat count, packet completion, and a backend-stall timeout.

## Interface
- FIFO_DEPTH, 8'd8: FIFO entries; power of two, 4..128.
- BK_RDY_TIMEOUT, 8'd5: consecutive stalled cycles before `bk_nordy` asserts.

- axi_aclk  in  1  single clock; all logic on rising edge.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- axis_tvalid  in  1  upstream beat valid.
- axis_tdata  in  32  beat data.
- axis_tstrb  in  4  byte strobes.
- axis_tkeep  in  4  byte keeps.
- axis_tlast  in  1  last beat of packet.
- axis_tuser  in  2  sideband.
- axis_tready  out  1  slave can accept a beat.
- bk_valid  out  1  head-of-FIFO beat available.
- bk_data  out  32  head beat data; zero when empty.
- bk_tstrb  out  4  head strobes; zero when empty.
- bk_tkeep  out  4  head keeps; zero when empty.
- bk_user  out  2  head tuser; zero when empty.
- bk_last  out  1  head beat carries tlast; zero when empty.
- bk_ready  in  1  backend consumes head beat.
- bk_beat_cnt  out  16  beats popped in the current packet.
- bk_done  out  1  one-cycle pulse after a packet's last beat is popped.
- bk_nordy  out  1  backend stall timeout.

## Operation
- Entry = {tdata, tstrb, tkeep, tuser, tlast}, 43 bits.
- Accept: `axis_tvalid && axis_tready`. Pop: `bk_valid && bk_ready`.
- `axis_tready = ~full`, where full derives from the registered occupancy only; a pop in the same cycle does not enable a write into a full FIFO.
- Null beats: an accepted beat with `tkeep==4'h0` and `tlast==0` is discarded (handshaked, not stored). `tkeep==0` with `tlast==1` is stored so the packet still terminates.
- Pointers: log2(FIFO_DEPTH)+1 bits; wrap by natural overflow; empty when equal; full when MSBs differ and remaining bits are equal.
- Simultaneous push and pop, not full and not empty: both occur; occupancy unchanged.
- Packet FSM:
  - PKT_IDLE: no beat of the current packet popped. A pop with last=0 goes to PKT_BUSY; a pop with last=1 goes to PKT_DONE.
  - PKT_BUSY: a pop with last=1 goes to PKT_DONE.
  - PKT_DONE: lasts one cycle, drives `bk_done=1`, then returns to PKT_IDLE. A pop in PKT_DONE is legal and is handled as it would be in PKT_IDLE, so back-to-back packets are supported.
- `bk_beat_cnt`: increments on every pop. On entry to PKT_DONE it holds the full packet length. It is cleared to 0 in PKT_DONE unless that cycle pops, in which case it loads 1. It saturates at 16'hFFFF.
- Stall counter (8 bits, saturating at 8'hFF):
  - increments when `bk_valid && ~bk_ready`;
  - clears on a pop or when empty.
  - `bk_nordy = (cnt >= BK_RDY_TIMEOUT)`.

## Timing
- Reset values: `axis_tready=1` once reset deasserts (0 during reset); all `bk_*` outputs 0; FSM in PKT_IDLE; pointers and counters 0.
- Latency: a beat accepted at edge N is visible on `bk_*` with `bk_valid=1` from just after edge N (1-cycle fill latency). No combinational path from `axis_*` to `bk_*`.
- `bk_*` data fields are combinational from the head entry and change only after a pop edge.
- `bk_done` is registered: it asserts in the cycle following the edge that popped the last beat, for exactly one cycle.
- `axis_tready` falls the cycle after the FIFO_DEPTH-th stored beat. It rises the cycle after the next pop.
- `bk_nordy` asserts BK_RDY_TIMEOUT cycles after the stall begins and deasserts the cycle after a pop.
- Asserting reset mid-packet discards FIFO contents and the FSM, and suppresses `bk_done`.

## Structure
- Package `axis_pkg`:
  - `axis_pkt_state_e` {PKT_IDLE, PKT_BUSY, PKT_DONE};
  - field width localparams (DATA 32, STRB 4, KEEP 4, USER 2);
  - entry width 43;
  - the entry packing order.
- Sub-module `axis_rx_fifo`: a synchronous FWFT FIFO with WIDTH/DEPTH parameters, wr_vld/wr_rdy/rd_vld/rd_rdy ports, and full/empty based on registered state. The FSM, counters and null-beat filter live in `axis_slave`.

## Test plan
- Single beat: tdata=32'hA5A5_0001, tkeep=4'hF, tlast=1, bk_ready=1 → `bk_valid` one cycle later; `bk_done` pulses the next cycle; `bk_beat_cnt` reads 1 during the pulse.
- 12-beat packet, bk_ready=0 until the FIFO fills → `axis_tready` drops after 8 beats. With bk_ready=1, all 12 beats arrive in order, `bk_last` is set only on beat 12, and `bk_done` pulses once with count 12.
- Null beats: 3 beats, the middle one with tkeep=0 and tlast=0 → 2 beats delivered. Then a lone beat with tkeep=0 and tlast=1 → delivered with `bk_last=1`.
- Back-to-back packets of lengths 2 and 3 with bk_ready held at 1 → two `bk_done` pulses; the second reports count 3, and the count restarts at 1 in the PKT_DONE cycle.
- Stall: one beat buffered, bk_ready=0 for 7 cycles → `bk_nordy=1` from stall cycle 5 and clears the cycle after the pop.
- Reset asserted after 4 of 6 beats → all outputs return to reset values immediately; no `bk_done`. A subsequent 1-beat packet delivers normally.
